// File: rtl/percept_pkg.sv
// percept_pkg: shared types and width helpers for the perceptron dot-product engine.
// Holds the controller state encoding plus the constant functions used to size
// the accumulator and the pair index from the module parameters.
package percept_pkg;

   // Controller states: waiting for commands, streaming products, publishing the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } perceptState_e;

   // Ceiling log2; clog2(1) is 0 so a single-pair engine adds no accumulator guard bits.
   function automatic int clog2(input int value);
      int bits;
      int rem;
      bits = 0;
      rem  = value - 1;
      while (rem > 0) begin
         bits = bits + 1;
         rem  = rem >> 1;
      end
      return bits;
   endfunction

   // Accumulator width: a full signed product plus enough headroom for N additions,
   // plus one extra bit so the most negative product sum still fits without overflow.
   function automatic int accWidth(input int width, input int nInputs);
      return 2 * width + clog2(nInputs) + 1;
   endfunction

   // Pair index width: must count 0..N inclusive so the drain cycle is recognisable.
   function automatic int idxWidth(input int nInputs);
      return clog2(nInputs + 1);
   endfunction

endpackage

// File: rtl/percept_clamp.sv
// percept_clamp: combinational fit of the wide signed accumulator onto the result width.
// Macro PERCEPT_SAT_EN: when defined, out-of-range sums saturate to the signed
// result range; when undefined, the sum wraps (low bits kept). A result width
// at least as wide as the accumulator simply sign-extends in both builds.
module percept_clamp
   import percept_pkg::*;
#(
   parameter int ACC_W = 19,
   parameter int OUT_W = 16
) (
   input  logic [ACC_W-1:0] acc_i,
   output logic [OUT_W-1:0] res_o
);

   generate
      if (OUT_W >= ACC_W) begin : g_extend
         // Every accumulator value is representable, so just sign-extend.
         assign res_o = OUT_W'($signed(acc_i));
      end else begin : g_narrow
`ifdef PERCEPT_SAT_EN
         // The value fits only when all bits from the result sign bit upward agree.
         localparam int HEAD_W = ACC_W - OUT_W + 1;
         logic [HEAD_W-1:0] head;
         logic              fits;

         assign head = acc_i[ACC_W-1:OUT_W-1];
         assign fits = (head == '0) || (head == '1);

         // Pass the value through when it fits, otherwise pin it to the rail on its sign side.
         always_comb begin
            res_o = acc_i[OUT_W-1:0];
            if (!fits) begin
               res_o = acc_i[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                      : {1'b0, {(OUT_W-1){1'b1}}};
            end
         end
`else
         // Two's-complement wrap discards the upper accumulator bits on purpose.
         logic unusedHead;
         assign unusedHead = ^acc_i[ACC_W-1:OUT_W];
         assign res_o      = acc_i[OUT_W-1:0];
`endif
      end
   endgenerate

endmodule

// File: rtl/percept_array.sv
// percept_array: serial-load perceptron dot-product engine for the neuron fabric.
// N signed (x, w) pairs arrive MSB-first on a 1-bit load chain, a pipelined
// multiply-accumulate walks the pairs after start, and the fitted result is
// returned MSB-first on a 1-bit output. Output fit is selected by the macro
// PERCEPT_SAT_EN inside percept_clamp, so this file is macro-free.
module percept_array
   import percept_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int N_INPUTS = 4,
   parameter int OUT_W    = 2 * WIDTH
) (
   input  logic clk,
   input  logic rst,
   input  logic shift_in,
   input  logic data_in,
   input  logic start,
   input  logic shift_out,
   output logic data_out,
   output logic busy,
   output logic done
);

   localparam int ACC_W  = accWidth(WIDTH, N_INPUTS);
   localparam int IDX_W  = idxWidth(N_INPUTS);
   localparam int CHAIN_W = 2 * N_INPUTS * WIDTH;
   localparam int PROD_W = 2 * WIDTH;

   perceptState_e            state_q;
   logic [CHAIN_W-1:0]       chain_q;
   logic [IDX_W-1:0]         idx_q;
   logic signed [PROD_W-1:0] prod_q;
   logic signed [PROD_W-1:0] prod_d;
   logic signed [ACC_W-1:0]  acc_q;
   logic [OUT_W-1:0]         result_q;
   logic [OUT_W-1:0]         result_d;
   logic                     dataOut_q;
   logic                     busy_q;
   logic                     done_q;
   logic signed [WIDTH-1:0]  xSel;
   logic signed [WIDTH-1:0]  wSel;

   // Pick the pair addressed by idx out of the chain and form its full-width signed product.
   // Pair k sits at the top of the chain in order x_0, w_0, x_1, w_1, ...; an index past
   // the last pair (the drain cycle) selects zeros, and that product is never accumulated.
   always_comb begin
      xSel = '0;
      wSel = '0;
      for (int k = 0; k < N_INPUTS; k++) begin
         if (int'(idx_q) == k) begin
            xSel = chain_q[CHAIN_W-1-(2*k)*WIDTH -: WIDTH];
            wSel = chain_q[CHAIN_W-1-(2*k+1)*WIDTH -: WIDTH];
         end
      end
      prod_d = PROD_W'(xSel) * PROD_W'(wSel);
   end

   percept_clamp #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
   ) u_clamp (
      .acc_i (acc_q),
      .res_o (result_d)
   );

   // Controller and datapath: command decode in IDLE, one product per RUN cycle with
   // accumulation lagging by one cycle, then a single DONE cycle that publishes the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         chain_q   <= '0;
         idx_q     <= '0;
         prod_q    <= '0;
         acc_q     <= '0;
         result_q  <= '0;
         dataOut_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  acc_q   <= '0;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else if (shift_in) begin
                  chain_q <= {chain_q[CHAIN_W-2:0], data_in};
               end else if (shift_out) begin
                  dataOut_q <= result_q[OUT_W-1];
                  result_q  <= result_q << 1;
               end
            end
            RUN: begin
               prod_q <= prod_d;
               if (idx_q != '0) begin
                  acc_q <= acc_q + ACC_W'(prod_q);
               end
               if (idx_q == IDX_W'(N_INPUTS)) begin
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            DONE: begin
               result_q <= result_d;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign data_out = dataOut_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_percept_array.sv
// tb_percept_array: directed and randomized checks of percept_array against a
// dot-product model computed with plain integer arithmetic. Honors PERCEPT_SAT_EN
// in the model so the same bench covers both output-fit builds.
module tb_percept_array;

   localparam int W     = 8;
   localparam int N     = 4;
   localparam int OUT_W = 16;

   logic clk;
   logic rst;
   logic shift_in;
   logic data_in;
   logic start;
   logic shift_out;
   logic data_out;
   logic busy;
   logic done;

   int testCount;
   int failCount;
   int xv[N];
   int wv[N];
   logic [OUT_W-1:0] readVal;
   int doneSeen;

   percept_array #(
      .WIDTH    (W),
      .N_INPUTS (N),
      .OUT_W    (OUT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .shift_in  (shift_in),
      .data_in   (data_in),
      .start     (start),
      .shift_out (shift_out),
      .data_out  (data_out),
      .busy      (busy),
      .done      (done)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it, where outputs are sampled and inputs driven.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single comparison point: counts the test and reports any disagreement.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference: exact integer dot product of the current vectors.
   function automatic longint dotModel();
      longint sum;
      sum = 0;
      for (int k = 0; k < N; k++) begin
         sum += longint'(xv[k]) * longint'(wv[k]);
      end
      return sum;
   endfunction

   // Reference: fit the exact sum onto the result width, clamping or wrapping.
   function automatic logic [OUT_W-1:0] fitModel(input longint acc);
      longint v;
      v = acc;
`ifdef PERCEPT_SAT_EN
      begin
         longint hi;
         longint lo;
         hi = (longint'(1) <<< (OUT_W - 1)) - 1;
         lo = -(longint'(1) <<< (OUT_W - 1));
         if (v > hi) v = hi;
         else if (v < lo) v = lo;
      end
`endif
      return OUT_W'(v);
   endfunction

   // Shift one signed field into the load chain, MSB first.
   task automatic shiftField(input int value);
      logic [W-1:0] bits;
      bits = W'(value);
      for (int b = W - 1; b >= 0; b--) begin
         shift_in = 1'b1;
         data_in  = bits[b];
         tick();
      end
   endtask

   // Load all pairs in chain order x_0, w_0, x_1, w_1, ...
   task automatic loadVector();
      for (int k = 0; k < N; k++) begin
         shiftField(xv[k]);
         shiftField(wv[k]);
      end
      shift_in = 1'b0;
      data_in  = 1'b0;
   endtask

   // Issue start and follow the handshake: latency to done, busy length, single-cycle done.
   // With noise set, shift_in/shift_out/data_in toggle randomly while the engine is busy.
   task automatic applyStimulus(input string tag, input bit noise, input bit startWithShift);
      int cycle;
      int busyCount;
      bit seen;
      start = 1'b1;
      if (startWithShift) begin
         shift_in = 1'b1;
         data_in  = 1'b1;
      end
      tick();
      start     = 1'b0;
      shift_in  = 1'b0;
      data_in   = 1'b0;
      busyCount = (busy === 1'b1) ? 1 : 0;
      cycle     = 0;
      seen      = 1'b0;
      while (!seen && cycle < 40) begin
         if (noise) begin
            shift_in  = 1'($urandom_range(0, 1));
            shift_out = 1'($urandom_range(0, 1));
            data_in   = 1'($urandom_range(0, 1));
         end
         tick();
         cycle++;
         if (done === 1'b1) seen = 1'b1;
         else if (busy === 1'b1) busyCount++;
      end
      shift_in  = 1'b0;
      shift_out = 1'b0;
      data_in   = 1'b0;
      checkOutput({tag, "_latency"}, 64'(cycle), 64'(N + 2));
      checkOutput({tag, "_busyLen"}, 64'(busyCount), 64'(N + 2));
      checkOutput({tag, "_busyOff"}, 64'(busy), 64'(0));
      tick();
      checkOutput({tag, "_donePulse"}, 64'(done), 64'(0));
   endtask

   // Stream the whole result out MSB first.
   task automatic readResult(output logic [OUT_W-1:0] val);
      val = '0;
      for (int k = 0; k < OUT_W; k++) begin
         shift_out = 1'b1;
         tick();
         val = {val[OUT_W-2:0], data_out};
      end
      shift_out = 1'b0;
   endtask

   // Load, compute and read back the current vectors, comparing against the model.
   task automatic runVector(input string tag);
      loadVector();
      applyStimulus(tag, 1'b0, 1'b0);
      readResult(readVal);
      checkOutput({tag, "_result"}, 64'(readVal), 64'(fitModel(dotModel())));
   endtask

   initial begin
      testCount = 0;
      failCount = 0;
      rst       = 1'b1;
      shift_in  = 1'b0;
      data_in   = 1'b0;
      start     = 1'b0;
      shift_out = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      checkOutput("reset_dataOut", 64'(data_out), 64'(0));
      checkOutput("reset_busy", 64'(busy), 64'(0));
      checkOutput("reset_done", 64'(done), 64'(0));

      // Small mixed-sign vector, then a repeat start on the untouched chain.
      xv = '{3, 2, 0, 0};
      wv = '{-1, 4, 0, 0};
      runVector("basic");
      applyStimulus("repeat", 1'b0, 1'b0);
      readResult(readVal);
      checkOutput("repeat_result", 64'(readVal), 64'(fitModel(dotModel())));

      // Positive and negative extremes exercising the output fit.
      xv = '{127, 127, 127, 127};
      wv = '{127, 127, 127, 127};
      runVector("maxPos");
      xv = '{-128, -128, -128, -128};
      wv = '{127, 127, 127, 127};
      runVector("maxNeg");

      // Random full-range vectors.
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < N; k++) begin
            xv[k] = int'($urandom_range(0, 255)) - 128;
            wv[k] = int'($urandom_range(0, 255)) - 128;
         end
         runVector($sformatf("rand%0d", r));
      end

      // Reset two cycles into a run: engine idles, no done, everything cleared.
      xv = '{3, 2, 0, 0};
      wv = '{-1, 4, 0, 0};
      loadVector();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("abort_busy", 64'(busy), 64'(0));
      checkOutput("abort_done", 64'(done), 64'(0));
      doneSeen = 0;
      for (int c = 0; c < N + 4; c++) begin
         tick();
         if (done !== 1'b0) doneSeen++;
      end
      checkOutput("abort_noDone", 64'(doneSeen), 64'(0));
      readResult(readVal);
      checkOutput("abort_result", 64'(readVal), 64'(0));
      applyStimulus("clearedChain", 1'b0, 1'b0);
      readResult(readVal);
      checkOutput("clearedChain_result", 64'(readVal), 64'(0));
      runVector("reload");

      // Commands during RUN are ignored; start beats shift_in in IDLE.
      applyStimulus("noisyRun", 1'b1, 1'b0);
      readResult(readVal);
      checkOutput("noisyRun_result", 64'(readVal), 64'(fitModel(dotModel())));
      applyStimulus("startShift", 1'b0, 1'b1);
      readResult(readVal);
      checkOutput("startShift_result", 64'(readVal), 64'(fitModel(dotModel())));
      applyStimulus("afterConflict", 1'b0, 1'b0);
      readResult(readVal);
      checkOutput("afterConflict_result", 64'(readVal), 64'(fitModel(dotModel())));

      // Back-to-back: second start right after done falls.
      applyStimulus("b2bFirst", 1'b0, 1'b0);
      applyStimulus("b2bSecond", 1'b0, 1'b0);
      readResult(readVal);
      checkOutput("b2b_result", 64'(readVal), 64'(fitModel(dotModel())));

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/percept_array.md
# percept_array

Parametrised serial-load perceptron dot-product engine, successor to the single-pair perceptron cell. It holds N signed input/weight pairs loaded over a 1-bit serial link and computes their dot product with a pipelined multiply-accumulate FSM on a start/busy/done handshake. The result is clamped or wrapped to a configurable output width and returned over a 1-bit serial link. It sits in the FPGA neuron fabric; one instance per neuron, daisy-chainable through the serial ports.

## Interface
- WIDTH, 8: bit width of each signed input x_i and weight w_i
- N_INPUTS, 4: number of (x, w) pairs, ≥1
- OUT_W, 2*WIDTH: signed result width returned on data_out
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- shift_in  in  1  shift load chain one bit, data_in enters LSB
- data_in  in  1  serial load bit
- start  in  1  begin dot-product computation
- shift_out  in  1  shift result register one bit toward data_out
- data_out  out  1  registered serial result bit, MSB first
- busy  out  1  computation in progress
- done  out  1  one-cycle pulse when result register loaded

## Operation
- Load chain L = 2·N_INPUTS·WIDTH bits, shifts left. After L shift_in cycles, the first bit shifted is chain MSB. Field order from MSB: x_0, w_0, x_1, w_1, … Each field MSB first, two's complement.
- Internal accumulator ACC_W = 2·WIDTH + clog2(N_INPUTS) + 1 bits, signed. It never overflows.
- FSM states: IDLE, RUN, DONE.
  - IDLE: command priority is start > shift_in > shift_out; lower commands in the same cycle are ignored. start clears the accumulator and index, then goes to RUN.
  - RUN: each cycle, the product register takes x_idx·w_idx (full 2·WIDTH signed) while idx advances. From the second RUN cycle, acc += product (sign-extended). RUN lasts N_INPUTS+1 cycles, covering N products plus one drain cycle, then goes to DONE.
  - DONE: result register ← fit(acc) per Configuration; done=1; next state IDLE.
- shift_out in IDLE: data_out ← result[OUT_W-1]; result ← result << 1 (zero fill).
- shift_in, shift_out and start are ignored outside IDLE. The load chain is unchanged by computation, so repeat starts recompute the same result.
- rst in any state: state IDLE. Load chain, product, accumulator, result, idx, data_out, busy and done all become 0. No done pulse is issued for an aborted run.

## Timing
- Reset values: data_out=0, busy=0, done=0.
- start sampled at edge E0. busy=1 from E0 until cleared at edge E(N_INPUTS+2).
- Result register loaded and done=1 at edge E(N_INPUTS+2); done cleared at the next edge.
- A new start is accepted in the cycle after done falls, which is the earliest cycle back in IDLE.
- data_out changes only on a shift_out edge. Sampled after K shift_outs, it is result bit OUT_W-K.

## Configuration
- PERCEPT_SAT_EN defined: fit() saturates acc to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- PERCEPT_SAT_EN undefined: fit() truncates to acc[OUT_W-1:0] (two's-complement wrap).
- If OUT_W ≥ ACC_W, both modes sign-extend identically.

## Structure
- Package percept_pkg holds:
  - FSM state enum (IDLE/RUN/DONE)
  - clog2 helper function
  - ACC_W derivation function
- Sub-module percept_clamp is the combinational fit from ACC_W to OUT_W. It contains the PERCEPT_SAT_EN ifdef, so the top level is macro-free.

## Test plan
- WIDTH=4, N=2, x=(3,2), w=(-1,4): load 16 bits, start, then 8 shift_outs. Expect done at E4 and result 5 (0x05); busy high for exactly 4 cycles.
- WIDTH=8, N=4, OUT_W=16, all x=w=127, acc=64516: with PERCEPT_SAT_EN result=32767 (0x7FFF); without it result=0xFC04 (-1020).
- WIDTH=8, N=4, OUT_W=16, all x=-128, w=127, acc=-65024: with SAT result=-32768 (0x8000); without it result=0x0200 (512).
- Reset mid-run: assert rst 2 cycles after start. Expect busy=0 next cycle, no done pulse, and data_out=0 after 16 shift_outs. After reload of the first vector, start gives 5.
- Command conflicts: shift_in and shift_out toggled during RUN leave the load chain and result unchanged, so the result still equals 5. In IDLE, start together with shift_in starts the computation and the chain is not shifted.
- Back-to-back: start raised again the cycle after done falls. Expect identical result and a second done at the same relative latency.
